// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, carry held in a flop.
// States: IDLE = waiting for start_i | RUN = one bit per edge | DONE = done_o pulse.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;

  logic             s_bit, carry;
  logic [WIDTH-1:0] sum_next;

  assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
  assign carry    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  // Partial sum holds only WIDTH-1 bits; the last bit joins it on the final edge.
  assign sum_next = {s_bit, psum_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          c_d     = cin_i;
          cnt_d   = '0;
          psum_d  = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        c_d    = carry;
        psum_d = sum_next[WIDTH-1:1];
        if (cnt_q == LAST) begin
          sum_d   = sum_next;
          cout_d  = carry;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder: an 8-bit instance for table vectors and
// sequencing corner cases, a 3-bit instance swept exhaustively.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start3, cin3, busy3, done3, cout3;
  logic [2:0] a3, b3, sum3;

  int n_vec = 0;
  int n_err = 0;

  bit_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .cin_i(cin8),
    .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8)
  );

  bit_serial_adder #(.WIDTH(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3), .a_i(a3), .b_i(b3), .cin_i(cin3),
    .busy_o(busy3), .done_o(done3), .sum_o(sum3), .cout_o(cout3)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one 8-bit operation from IDLE; lat = cycles from accepting edge to done_o.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
    chk("busy_after_accept", {31'd0, busy8}, 32'd1);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done8) lat = i;
    end
  endtask

  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic c, output int lat);
    @(negedge clk);
    start3 = 1'b1; a3 = a; b3 = b; cin3 = c;
    @(posedge clk); #1;
    start3 = 1'b0; a3 = ~a; b3 = ~b; cin3 = ~c;
    lat = -1;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done3) lat = i;
    end
  endtask

  initial begin
    automatic int lat, dcnt, dlat, unstable, lows, adj_low, bad_gap, last_done, bad_lat3;
    automatic logic [7:0] dsum, held;
    automatic logic dc, prev_low;
    automatic int exp3;

    vecs[0] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[1] = '{a: 8'h5A, b: 8'hA5, cin: 1'b1, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b1, sum: 8'h01, cout: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};
    vecs[6] = '{a: 8'hC8, b: 8'h64, cin: 1'b0, sum: 8'h2C, cout: 1'b1};
    vecs[7] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_sum8",  {24'd0, sum8},  32'd0);
    chk("rst_cout8", {31'd0, cout8}, 32'd0);
    chk("rst_busy3", {31'd0, busy3}, 32'd0);
    chk("rst_sum3",  {28'd0, cout3, sum3}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      op8(vecs[k].a, vecs[k].b, vecs[k].cin, lat);
      chk("latency8", lat, 32'd8);
      chk("sum8", {24'd0, sum8}, {24'd0, vecs[k].sum});
      chk("cout8", {31'd0, cout8}, {31'd0, vecs[k].cout});
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, done8}, 32'd0);
      chk("busy_fall", {31'd0, busy8}, 32'd0);
    end

    // start_i pulses in RUN cycles 2 and 5 and during DONE must be ignored
    held = sum8;
    dcnt = 0; dlat = -1; unstable = 0; dsum = '0; dc = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h4B; cin8 = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 14; i++) begin
      start8 = (i == 2 || i == 5 || i == 9);
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      @(posedge clk); #1;
      if (done8) begin
        dcnt++; dlat = i; dsum = sum8; dc = cout8;
      end else if (dcnt == 0 && sum8 !== held) begin
        unstable++;
      end
    end
    start8 = 1'b0;
    chk("ign_done_count", dcnt, 32'd1);
    chk("ign_latency", dlat, 32'd8);
    chk("ign_sum", {24'd0, dsum}, 32'h87);
    chk("ign_cout", {31'd0, dc}, 32'd0);
    chk("sum_stable_in_run", unstable, 32'd0);
    chk("ign_idle_after", {31'd0, busy8}, 32'd0);

    // reset mid-RUN aborts the operation
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_sum",  {24'd0, sum8},  32'd0);
    chk("abort_cout", {31'd0, cout8}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) dcnt++;
    end
    chk("abort_no_done", dcnt, 32'd0);
    op8(8'h11, 8'h22, 1'b1, lat);
    chk("post_abort_lat", lat, 32'd8);
    chk("post_abort_sum", {24'd0, sum8}, 32'h34);
    chk("post_abort_cout", {31'd0, cout8}, 32'd0);
    @(posedge clk); #1;

    // start_i held high: back-to-back operations every WIDTH+2 cycles
    dcnt = 0; lows = 0; adj_low = 0; bad_gap = 0; last_done = -1; dlat = -1; prev_low = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        dcnt++;
        if (last_done < 0) dlat = i;
        else if (i - last_done != 10) bad_gap++;
        last_done = i;
      end
      if (!busy8) begin
        lows++;
        if (prev_low) adj_low++;
      end
      prev_low = !busy8;
    end
    start8 = 1'b0;
    chk("held_done_count", dcnt, 32'd4);
    chk("held_first_done", dlat, 32'd9);
    chk("held_done_period", bad_gap, 32'd0);
    chk("held_busy_low_cycles", lows, 32'd4);
    chk("held_busy_low_runs", adj_low, 32'd0);
    chk("held_sum", {24'd0, sum8}, 32'h03);
    repeat (12) @(posedge clk);

    // WIDTH=3 exhaustive against a+b+cin
    bad_lat3 = 0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          op3(3'(a), 3'(b), 1'(c), lat);
          if (lat != 3) bad_lat3++;
          exp3 = a + b + c;
          chk("w3_sum", {28'd0, cout3, sum3}, 32'(exp3));
          @(posedge clk);
        end
      end
    end
    chk("w3_latency", bad_lat3, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Multi-cycle adder that adds two WIDTH-bit operands one bit per clock through a single one-bit full-adder datapath, carrying the carry-out forward in a register to the next bit. It sits directly upstream of the one-bit full-adder cell. It sequences operand bits LSB-first into the cell's a/b/cin inputs and collects its sum/carry outputs into a parallel result. It is the team's area-minimal alternative to a ripple-carry adder and exercises the full-adder cell under real sequential control.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk_i  input  1  rising-edge clock.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE.
- a_i  input  WIDTH  operand A; captured on the accepting edge.
- b_i  input  WIDTH  operand B; captured on the accepting edge.
- cin_i  input  1  carry-in; captured on the accepting edge.
- busy_o  output  1  high whenever state is not IDLE.
- done_o  output  1  one-cycle pulse; result valid.
- sum_o  output  WIDTH  registered sum; holds the last completed result.
- cout_o  output  1  registered carry-out; holds the last completed result.

## Operation
- One clock and one reset domain: clk_i, with rst_i synchronous and active-high.
- Reset sets state to IDLE and clears all internal registers. Output reset values: busy_o=0, done_o=0, sum_o=0, cout_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1 on an edge, load the A and B shift registers from a_i and b_i.
  - Load the carry register from cin_i and clear the bit counter.
  - Go to RUN.
  - Otherwise remain in IDLE.
- RUN, on each edge:
  - Compute s = A[0]^B[0]^c and the new carry = majority(A[0],B[0],c).
  - Shift s into the partial-sum register from the MSB side (right shift), so bit 0 ends up in the LSB after WIDTH shifts.
  - Shift A and B right by one and increment the counter.
- On the edge processing bit WIDTH-1:
  - Copy the completed partial sum to sum_o and the final carry to cout_o.
  - Go to DONE.
- DONE: done_o=1 for this single cycle. The next edge always returns to IDLE.
- start_i is ignored in RUN and DONE. It is not queued.
- Operand inputs are don't-care except on the accepting edge. Changing a_i, b_i or cin_i mid-operation has no effect.
- Arithmetic: {cout_o,sum_o} = a_i + b_i + cin_i, computed modulo 2^(WIDTH+1). Overflow is reported only through cout_o.
- sum_o and cout_o change only on the DONE-entry edge (or on reset). They are stable at all other times, including during RUN.
- Reset asserted in any state, including mid-RUN, takes priority over everything:
  - The operation is aborted and no done_o pulse is produced.
  - sum_o and cout_o are cleared to 0.
- The counter is $clog2(WIDTH) bits wide and compares against WIDTH-1. It never wraps within an operation.

## Timing
- The accepting edge is E0. The RUN edges are E1..EWIDTH.
- DONE is entered at EWIDTH. done_o is high from EWIDTH to EWIDTH+1.
- Latency from the accepting edge to done_o rising is WIDTH cycles.
- busy_o rises at E0 and falls at EWIDTH+1.
- If start_i is held high continuously, a new operation is accepted every WIDTH+2 cycles: the IDLE cycle after DONE samples start_i.
- done_o and busy_o are registered outputs, with no combinational path from inputs.

## Test plan
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> done_o pulses exactly 8 cycles after the accepting edge; sum_o=8'h00, cout_o=1.
- WIDTH=8, a=8'h5A, b=8'hA5, cin=1 -> sum_o=8'h00, cout_o=1. Also a=8'h00, b=8'h00, cin=0 -> sum_o=8'h00, cout_o=0, with done_o still pulsing.
- Pulse start_i with new operands in cycles 2 and 5 of RUN, and again during DONE -> ignored; the result matches the original operands; exactly one done_o pulse.
- Assert rst_i for one cycle at RUN cycle 4 -> busy_o=0 next cycle, no done_o, sum_o=0, cout_o=0. A new start_i after reset produces a correct result.
- start_i held high for 40 cycles with WIDTH=8 -> done_o pulses every 10 cycles; busy_o is low for exactly one cycle between operations.
- WIDTH=3, exhaustive over all 128 combinations of a, b and cin -> {cout_o,sum_o} equals a+b+cin for every case, compared against a reference model.
